// File: rtl/uart_rx_fifo.sv
// UART receiver: 16x oversampling with 3-sample majority vote, optional parity,
// one or two stop bits, break detection and a show-ahead receive FIFO.
module uart_rx_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          rx_i,
  input  logic [15:0]                   baud_div_i,
  input  logic                          parity_en_i,
  input  logic                          parity_odd_i,
  input  logic                          two_stop_i,
  input  logic                          rd_i,
  input  logic                          clr_err_i,
  output logic [DATA_W-1:0]             data_o,
  output logic                          perr_o,
  output logic                          ferr_o,
  output logic                          valid_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output logic                          overrun_o,
  output logic                          busy_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DATA_W + 2;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_BREAK
  } state_t;

  state_t state_q, state_d;

  logic              rx_meta_q, rxs_q;
  logic [15:0]       tcnt_q, tcnt_d, div_q, div_d;
  logic [3:0]        scnt_q, scnt_d, bitcnt_q, bitcnt_d;
  logic              pen_q, pen_d, podd_q, podd_d, two_q, two_d;
  logic              pbit_q, pbit_d, perr_q, perr_d, ferr_q, ferr_d;
  logic              s7_q, s7_d, s8_q, s8_d;
  logic [DATA_W-1:0] shift_q, shift_d;

  logic [EW-1:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              overrun_q, overrun_d;

  logic tick, samp, maj, start_det, brk;
  logic push, push_perr, push_ferr;
  logic pop, full, wr_en;
  logic [EW-1:0] head;

  assign start_det = (state_q == S_IDLE) && !rxs_q;
  assign tick      = (state_q != S_IDLE) && (state_q != S_BREAK) && (tcnt_q == div_q);
  assign samp      = tick && (scnt_q == 4'd9);
  assign maj       = (s7_q & s8_q) | (s7_q & rxs_q) | (s8_q & rxs_q);
  // Break: all-zero data, zero parity bit (if any) and a low first stop bit.
  assign brk       = (shift_q == '0) && !pbit_q && !maj;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= S_IDLE;
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
      tcnt_q    <= '0;
      scnt_q    <= '0;
      bitcnt_q  <= '0;
      div_q     <= '0;
      pen_q     <= 1'b0;
      podd_q    <= 1'b0;
      two_q     <= 1'b0;
      pbit_q    <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_meta_q <= rx_i;
      rxs_q     <= rx_meta_q;
      tcnt_q    <= tcnt_d;
      scnt_q    <= scnt_d;
      bitcnt_q  <= bitcnt_d;
      div_q     <= div_d;
      pen_q     <= pen_d;
      podd_q    <= podd_d;
      two_q     <= two_d;
      pbit_q    <= pbit_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge clk_i) begin
    shift_q <= shift_d;
    s7_q    <= s7_d;
    s8_q    <= s8_d;
    if (wr_en) mem_q[wr_ptr_q] <= {push_perr, push_ferr, shift_q};
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (!rxs_q) state_d = S_START;
      S_START:  if (samp) state_d = maj ? S_IDLE : S_DATA;
      S_DATA:   if (samp && bitcnt_q == 4'(DATA_W - 1)) state_d = pen_q ? S_PARITY : S_STOP1;
      S_PARITY: if (samp) state_d = S_STOP1;
      S_STOP1:  if (samp) state_d = brk ? S_BREAK : (two_q ? S_STOP2 : S_IDLE);
      S_STOP2:  if (samp) state_d = S_IDLE;
      S_BREAK:  if (rxs_q) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o    = (state_q != S_IDLE);
    push      = samp && (((state_q == S_STOP1) && (brk || !two_q)) || (state_q == S_STOP2));
    push_perr = perr_q;
    push_ferr = (state_q == S_STOP2) ? (ferr_q | !maj) : !maj;
  end

  // Bit timing and frame datapath; config is captured only at the start edge.
  always_comb begin
    tcnt_d   = tcnt_q;
    scnt_d   = scnt_q;
    bitcnt_d = bitcnt_q;
    div_d    = div_q;
    pen_d    = pen_q;
    podd_d   = podd_q;
    two_d    = two_q;
    pbit_d   = pbit_q;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    s7_d     = s7_q;
    s8_d     = s8_q;
    shift_d  = shift_q;
    if (start_det) begin
      tcnt_d   = '0;
      scnt_d   = '0;
      bitcnt_d = '0;
      div_d    = baud_div_i;
      pen_d    = parity_en_i;
      podd_d   = parity_odd_i;
      two_d    = two_stop_i;
      pbit_d   = 1'b0;
      perr_d   = 1'b0;
      ferr_d   = 1'b0;
    end else if (state_q != S_IDLE && state_q != S_BREAK) begin
      tcnt_d = tick ? 16'd0 : tcnt_q + 16'd1;
      if (tick) begin
        scnt_d = scnt_q + 4'd1;
        if (scnt_q == 4'd7) s7_d = rxs_q;
        if (scnt_q == 4'd8) s8_d = rxs_q;
      end
      if (samp) begin
        unique case (state_q)
          S_DATA: begin
            shift_d  = {maj, shift_q[DATA_W-1:1]};
            bitcnt_d = bitcnt_q + 4'd1;
          end
          S_PARITY: begin
            pbit_d = maj;
            perr_d = maj ^ (^shift_q) ^ podd_q;
          end
          S_STOP1: ferr_d = !maj;
          default: ;
        endcase
      end
    end
  end

  assign pop   = rd_i && (count_q != '0);
  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign wr_en = push && (!full || pop);

  always_comb begin
    wr_ptr_d  = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    unique case ({wr_en, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A new drop takes priority over a clear in the same cycle.
    if (push && full && !pop) overrun_d = 1'b1;
    else if (clr_err_i)       overrun_d = 1'b0;
    else                      overrun_d = overrun_q;
  end

  assign head      = mem_q[rd_ptr_q];
  assign valid_o   = (count_q != '0);
  assign data_o    = valid_o ? head[DATA_W-1:0] : '0;
  assign ferr_o    = valid_o & head[DATA_W];
  assign perr_o    = valid_o & head[DATA_W+1];
  assign count_o   = count_q;
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: vector table of single frames plus sequences for
// break, glitch, overrun, mid-frame reset and a 7-bit build.
module tb_uart_rx_fifo;

  logic        clk = 1'b0;
  logic        rst_n, rx8, rx7, pen, podd, two, rd, clr;
  logic [15:0] div;

  logic [7:0]  d8;
  logic        perr8, ferr8, valid8, ovr8, busy8;
  logic [2:0]  cnt8;
  logic [6:0]  d7;
  logic        perr7, ferr7, valid7, ovr7, busy7;
  logic [3:0]  cnt7;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DATA_W(8), .FIFO_DEPTH(4)) dut8 (
    .clk_i(clk), .rst_i(rst_n), .rx_i(rx8), .baud_div_i(div),
    .parity_en_i(pen), .parity_odd_i(podd), .two_stop_i(two),
    .rd_i(rd), .clr_err_i(clr), .data_o(d8), .perr_o(perr8), .ferr_o(ferr8),
    .valid_o(valid8), .count_o(cnt8), .overrun_o(ovr8), .busy_o(busy8));

  uart_rx_fifo #(.DATA_W(7), .FIFO_DEPTH(8)) dut7 (
    .clk_i(clk), .rst_i(rst_n), .rx_i(rx7), .baud_div_i(div),
    .parity_en_i(pen), .parity_odd_i(podd), .two_stop_i(two),
    .rd_i(rd), .clr_err_i(clr), .data_o(d7), .perr_o(perr7), .ferr_o(ferr7),
    .valid_o(valid7), .count_o(cnt7), .overrun_o(ovr7), .busy_o(busy7));

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] d;
    logic       perr;
    logic       ferr;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [7:0]  d;
    logic        pen, podd, two, pbit, sbit;
    logic [15:0] div;
    logic        exp_perr, exp_ferr;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int bp();
    return 16 * (int'(div) + 1);
  endfunction

  task automatic bit_time(input logic v, input bit sel7);
    if (sel7) rx7 = v; else rx8 = v;
    repeat (bp()) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nb, input bit pe, input logic pb,
                            input logic sb, input bit tw, input bit sel7);
    bit_time(1'b0, sel7);
    for (int i = 0; i < nb; i++) bit_time(d[i], sel7);
    if (pe) bit_time(pb, sel7);
    bit_time(sb, sel7);
    if (tw) bit_time(1'b1, sel7);
    if (sel7) rx7 = 1'b1; else rx8 = 1'b1;
  endtask

  task automatic idle_bits(input int n);
    repeat (n * bp()) @(negedge clk);
  endtask

  task automatic sb_push(input logic [7:0] d, input logic pe, input logic fe);
    exp_t e;
    e.d = d; e.perr = pe; e.ferr = fe;
    sbq.push_back(e);
  endtask

  task automatic expect_pop(input string nm);
    exp_t e;
    int t = 0;
    while (!valid8 && t < 4000) begin
      @(negedge clk);
      t++;
    end
    chk({nm, "_valid"}, valid8, 1);
    if (sbq.size() == 0) begin
      chk({nm, "_sb_nonempty"}, 0, 1);
    end else if (valid8) begin
      e = sbq.pop_front();
      chk({nm, "_data"}, d8, e.d);
      chk({nm, "_perr"}, perr8, e.perr);
      chk({nm, "_ferr"}, ferr8, e.ferr);
      rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'hA5, 1, 0, 1, 0, 1, 16'd26, 0, 0};
    vecs[1] = '{8'h3C, 1, 0, 0, 1, 1, 16'd3,  1, 0};
    vecs[2] = '{8'h3C, 1, 1, 0, 1, 1, 16'd3,  0, 0};
    vecs[3] = '{8'h55, 0, 0, 0, 0, 0, 16'd3,  0, 1};
    vecs[4] = '{8'hFF, 1, 1, 1, 1, 1, 16'd3,  0, 0};
    vecs[5] = '{8'h00, 1, 0, 0, 0, 1, 16'd3,  0, 0};
    vecs[6] = '{8'h81, 0, 0, 1, 0, 1, 16'd3,  0, 0};
    vecs[7] = '{8'hC3, 1, 0, 1, 1, 1, 16'd3,  1, 0};

    rst_n = 1'b0; rx8 = 1'b1; rx7 = 1'b1; div = 16'd3;
    pen = 1'b0; podd = 1'b0; two = 1'b0; rd = 1'b0; clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data", d8, 0);
    chk("rst_perr", perr8, 0);
    chk("rst_ferr", ferr8, 0);
    chk("rst_valid", valid8, 0);
    chk("rst_count", cnt8, 0);
    chk("rst_overrun", ovr8, 0);
    chk("rst_busy", busy8, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      pen = vecs[v].pen; podd = vecs[v].podd; two = vecs[v].two; div = vecs[v].div;
      @(negedge clk);
      send_frame(vecs[v].d, 8, vecs[v].pen, vecs[v].pbit, vecs[v].sbit, vecs[v].two, 1'b0);
      sb_push(vecs[v].d, vecs[v].exp_perr, vecs[v].exp_ferr);
      idle_bits(2);
      chk($sformatf("vec%0d_count", v), cnt8, 1);
      expect_pop($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_empty", v), valid8, 0);
    end

    // Break: line low for 30 bit times gives exactly one entry.
    pen = 1'b0; podd = 1'b0; two = 1'b0; div = 16'd3;
    @(negedge clk);
    rx8 = 1'b0;
    idle_bits(30);
    chk("break_count_low", cnt8, 1);
    chk("break_busy_low", busy8, 1);
    rx8 = 1'b1;
    idle_bits(2);
    chk("break_busy_rel", busy8, 0);
    chk("break_count_rel", cnt8, 1);
    sb_push(8'h00, 1'b0, 1'b1);
    expect_pop("break");
    send_frame(8'h12, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    sb_push(8'h12, 1'b0, 1'b0);
    idle_bits(2);
    expect_pop("after_break");
    chk("after_break_empty", cnt8, 0);

    // Glitch of 3 ticks is rejected at the start-bit vote.
    rx8 = 1'b0;
    repeat (5) @(negedge clk);
    chk("glitch_busy", busy8, 1);
    repeat (7) @(negedge clk);
    rx8 = 1'b1;
    repeat (bp() - 12) @(negedge clk);
    chk("glitch_idle", busy8, 0);
    chk("glitch_count", cnt8, 0);

    // Overrun: five back-to-back frames into a 4-deep FIFO.
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      if (i <= 4) sb_push(8'(i), 1'b0, 1'b0);
    end
    idle_bits(2);
    chk("ovr_count", cnt8, 4);
    chk("ovr_flag", ovr8, 1);
    for (int i = 1; i <= 4; i++) expect_pop($sformatf("ovr_pop%0d", i));
    chk("ovr_sticky", ovr8, 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("ovr_clear", ovr8, 0);

    // Full FIFO with a pop in the exact push cycle of the fifth frame.
    for (int i = 6; i <= 9; i++) begin
      send_frame(8'(i), 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      sb_push(8'(i), 1'b0, 1'b0);
    end
    idle_bits(2);
    chk("pp_full", cnt8, 4);
    sb_push(8'h0A, 1'b0, 1'b0);
    fork
      send_frame(8'h0A, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      begin
        exp_t e;
        repeat (3 + int'(div) + (9 + 16 * 9) * (int'(div) + 1)) @(posedge clk);
        @(negedge clk);
        e = sbq.pop_front();
        chk("pp_head", d8, e.d);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
      end
    join
    idle_bits(2);
    chk("pp_count", cnt8, 4);
    chk("pp_no_ovr", ovr8, 0);
    for (int i = 7; i <= 10; i++) expect_pop($sformatf("pp_pop%0d", i));
    chk("pp_empty", cnt8, 0);

    // Reset asserted during data bit 3 with one entry already queued.
    send_frame(8'h33, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle_bits(1);
    fork
      send_frame(8'h77, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      begin
        repeat (4 * bp() + bp() / 2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_busy", busy8, 0);
        chk("mrst_count", cnt8, 0);
        chk("mrst_valid", valid8, 0);
        chk("mrst_data", d8, 0);
        chk("mrst_ferr", ferr8, 0);
      end
    join
    sbq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    idle_bits(2);
    send_frame(8'h9E, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    sb_push(8'h9E, 1'b0, 1'b0);
    idle_bits(2);
    expect_pop("post_rst");

    // 7N1 frame on the 7-bit instance.
    send_frame(8'h41, 7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle_bits(2);
    chk("w7_valid", valid7, 1);
    chk("w7_data", d7, 7'h41);
    chk("w7_perr", perr7, 0);
    chk("w7_ferr", ferr7, 0);
    chk("w7_count", cnt7, 1);
    chk("w7_ovr", ovr7, 0);
    chk("w7_busy", busy7, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
